// File: rtl/op_issuer_if.sv
// Operand-pair handshake and compute-pair launch bundle for op_issuer.
interface op_issuer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] A;
    logic [7:0] B;
    logic       start;
    logic       busy;
    logic [2:0] fifo_cnt;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, A, B, start, busy, fifo_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, A, B, start, busy, fifo_cnt
    );
endinterface

// File: rtl/op_issuer.sv
// Queues operand pairs in a 4-deep FIFO and launches them as active-low start pulses.
// Optional OP_ISSUER_COUNT_EN adds an 8-bit wrapping issued_cnt output.
module op_issuer #(
    parameter int unsigned RUN_CYCLES = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    op_issuer_if.slave bus
`ifdef OP_ISSUER_COUNT_EN
    ,
    output logic [7:0] issued_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    localparam logic [3:0] RUN_LAST = 4'(RUN_CYCLES - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  phase, phase_nxt;
    logic [15:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        push, load;

    // Ready comes from the registered count only, so a full FIFO never accepts
    // even in a cycle where the head is being popped.
    assign bus.in_ready = (count < 3'd4);
    assign bus.fifo_cnt = count;
    assign bus.start    = (state != RUN);
    assign bus.busy     = (state != IDLE);
    assign push         = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (count != 3'd0) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                    phase_nxt = 4'd0;
                end
            end
            RUN: begin
                if (phase == RUN_LAST) begin
                    state_nxt = GAP;
                    phase_nxt = 4'd0;
                end else begin
                    phase_nxt = phase + 4'd1;
                end
            end
            GAP: begin
                if (phase == GAP_LAST) begin
                    phase_nxt = 4'd0;
                    if (count != 3'd0) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    phase_nxt = phase + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            phase <= 4'd0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // Storage needs no reset: occupancy is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= {bus.in_a, bus.in_b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            bus.A  <= 8'd0;
            bus.B  <= 8'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (load) begin
                rd_ptr <= rd_ptr + 2'd1;
                bus.A  <= mem[rd_ptr][15:8];
                bus.B  <= mem[rd_ptr][7:0];
            end
            count <= count + 3'(push) - 3'(load);
        end
    end

`ifdef OP_ISSUER_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            issued_cnt <= 8'd0;
        else if (load)
            issued_cnt <= issued_cnt + 8'd1;
    end
`endif

endmodule

// File: doc/op_issuer.md
OP_ISSUER -- requirements
Module: op_issuer

Interface
REQ-001 The block SHALL have parameter RUN_CYCLES, default 4: the number of cycles start is held low per launch (legal range 1..15).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1: the number of cycles start is held high between launches (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  an operand pair is offered on in_a/in_b.
REQ-006 in_ready  output  1  the block can accept a pair this cycle.
REQ-007 in_a  input  8  operand A of the offered pair.
REQ-008 in_b  input  8  operand B of the offered pair.
REQ-009 A  output  8  registered operand A driven to the control_unit/data_path compute pair.
REQ-010 B  output  8  registered operand B driven to the compute pair.
REQ-011 start  output  1  launch level to the control_unit; active-low: 1 = idle, 0 = run.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 fifo_cnt  output  3  number of queued pairs (0..4).

Function
REQ-014 The block SHALL queue operand pairs in a 4-entry FIFO; a push occurs on any cycle with in_valid && in_ready.
REQ-015 in_ready SHALL equal (fifo_cnt < 4); it depends only on the registered count, with no same-cycle pass-through when full, even if a pop occurs in that cycle.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and GAP.
REQ-017 Load event: in IDLE, or on the last GAP cycle, with fifo_cnt > 0, the block SHALL register A/B from the FIFO head, pop it, and enter RUN on the next cycle.
REQ-018 In RUN, start SHALL be 0 for exactly RUN_CYCLES cycles; the FSM then enters GAP.
REQ-019 In GAP, start SHALL be 1 for exactly GAP_CYCLES cycles; at the last GAP cycle the FSM enters RUN if a load event occurs, otherwise IDLE.
REQ-020 A and B SHALL stay stable from the load event through the end of the following GAP, and SHALL hold their last values while in IDLE.
REQ-021 Latency: a push accepted at cycle N into an empty, idle block SHALL produce a load at N+1 and start=0 over cycles N+2 .. N+1+RUN_CYCLES.
REQ-022 On a simultaneous push and pop, fifo_cnt SHALL be unchanged, and the FIFO SHALL preserve order with read/write pointers wrapping modulo 4.
REQ-023 While empty, the block SHALL stay in IDLE with start=1; it SHALL never pop when empty.
REQ-024 Input pairs offered while in_ready=0 SHALL be ignored.

Reset
REQ-025 While reset is high at a rising edge, the block SHALL set: state=IDLE, FIFO empty (fifo_cnt=0, pointers 0), A=0, B=0, start=1, busy=0, in_ready=1.
REQ-026 Reset asserted mid-RUN or mid-GAP SHALL abort the launch and discard all queued pairs; start SHALL read 1 from the cycle after the reset edge.
REQ-027 A push offered in a reset cycle SHALL be dropped.

Configuration
REQ-028 With macro OP_ISSUER_COUNT_EN defined, the block SHALL add output issued_cnt (8 bits): reset to 0, incremented on each load event, wrapping 255 -> 0.
REQ-029 Without OP_ISSUER_COUNT_EN, the issued_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Single launch: reset, then push (3,8) at cycle N -> A=3 and B=8 from N+2; start=0 for cycles N+2..N+5; start=1 at N+6; IDLE at N+7.
REQ-031 Back-to-back launch: push (3,8) then (8,4) on consecutive cycles -> second load on the last GAP cycle; start high for exactly 1 cycle; A=8, B=4 during the second run.
REQ-032 Full FIFO: hold start-up busy, then offer 6 pairs -> at most 4 queued plus 1 loaded; in_ready=0 at fifo_cnt=4; pairs emerge in push order.
REQ-033 Reset mid-RUN: reset in the 2nd RUN cycle with 2 pairs queued -> start=1, fifo_cnt=0, A=B=0 next cycle, and no further launches.
REQ-034 Parameters RUN_CYCLES=1, GAP_CYCLES=3: push 2 pairs -> start low 1 cycle, high exactly 3 cycles, then low 1 cycle.
REQ-035 With OP_ISSUER_COUNT_EN: 257 pushes -> issued_cnt=1 after all launches complete.
